// File: rtl/waterfall_line_writer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// waterfall_line_writer_if : SDFT read, framebuffer write and status bundle
// rev 1.0
// ---------------------------------------------------------------------------
interface waterfall_line_writer_if #(
  parameter int LIMIT_BINS = 32,
  parameter int BIN_ADDR_W = $clog2(LIMIT_BINS),
  parameter int FREQ_W     = 16,
  parameter int PIX_W      = 4,
  parameter int ROWS       = 32,
  parameter int ROW_W      = $clog2(ROWS)
);
  logic                        line_req;
  logic                        sdft_ready;
  logic [FREQ_W-1:0]           sdft_bin_out;
  logic                        sdft_read;
  logic [BIN_ADDR_W-1:0]       sdft_bin_addr;
  logic                        fb_we;
  logic [ROW_W+BIN_ADDR_W-1:0] fb_addr;
  logic [PIX_W-1:0]            fb_data;
  logic [ROW_W-1:0]            top_row;
  logic                        busy;
  logic                        line_done;
  logic                        overrun;

  modport master (
    input  line_req, sdft_ready, sdft_bin_out,
    output sdft_read, sdft_bin_addr, fb_we, fb_addr, fb_data,
           top_row, busy, line_done, overrun
  );

  modport slave (
    output line_req, sdft_ready, sdft_bin_out,
    input  sdft_read, sdft_bin_addr, fb_we, fb_addr, fb_data,
           top_row, busy, line_done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/waterfall_line_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// waterfall_line_writer : sweeps SDFT bins into one scrolling framebuffer row
// rev 1.0
// ---------------------------------------------------------------------------
module waterfall_line_writer #(
  parameter int LIMIT_BINS = 32,
  parameter int BIN_ADDR_W = $clog2(LIMIT_BINS),
  parameter int FREQ_W     = 16,
  parameter int PIX_W      = 4,
  parameter int ROWS       = 32,
  parameter int ROW_W      = $clog2(ROWS),
  parameter int SHIFT      = 4,
  parameter int READ_LAT   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  waterfall_line_writer_if.master  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_SWEEP = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int                    CNT_W       = BIN_ADDR_W + 1;
  localparam logic [CNT_W-1:0]      C_RD_LAST   = CNT_W'(LIMIT_BINS);
  localparam logic [BIN_ADDR_W-1:0] C_COL_LAST  = BIN_ADDR_W'(LIMIT_BINS - 1);
  localparam logic [FREQ_W-1:0]     C_PIX_MAXW  = FREQ_W'((1 << PIX_W) - 1);
  localparam logic [PIX_W-1:0]      C_PIX_MAX   = PIX_W'((1 << PIX_W) - 1);

  logic [2:0]                  r_state;
  logic                        r_pending;
  logic                        r_read;
  logic [BIN_ADDR_W-1:0]       r_addr;
  logic [CNT_W-1:0]            r_rd_cnt;
  logic [READ_LAT-1:0]         r_vld;
  logic [BIN_ADDR_W-1:0]       r_cap_col;
  logic                        r_we;
  logic [ROW_W+BIN_ADDR_W-1:0] r_fb_addr;
  logic [PIX_W-1:0]            r_pix;
  logic [ROW_W-1:0]            r_row;
  logic [ROW_W-1:0]            r_top;
  logic                        r_done;
  logic                        r_ovr;

  logic                        w_busy;
  logic                        w_present;
  logic                        w_cap;
  logic                        w_last_wr;
  logic [FREQ_W-1:0]           w_shifted;
  logic [PIX_W-1:0]            w_pix;

  assign w_busy    = (r_state != S_IDLE);
  // The first read cycle carries an address the SDFT ignores, so it is not a column.
  assign w_present = r_read && (r_rd_cnt != '0);
  assign w_cap     = r_vld[READ_LAT-1];
  assign w_last_wr = r_we && (r_fb_addr[BIN_ADDR_W-1:0] == C_COL_LAST);
  assign w_shifted = bus.sdft_bin_out >> SHIFT;
  assign w_pix     = (w_shifted > C_PIX_MAXW) ? C_PIX_MAX : w_shifted[PIX_W-1:0];

  generate
    if (READ_LAT == 1) begin : g_vld_one
      always_ff @(posedge clk) begin
        if (!reset_n) r_vld <= '0;
        else          r_vld <= w_present;
      end
    end else begin : g_vld_deep
      always_ff @(posedge clk) begin
        if (!reset_n) r_vld <= '0;
        else          r_vld <= {r_vld[READ_LAT-2:0], w_present};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_read    <= 1'b0;
      r_addr    <= '0;
      r_rd_cnt  <= '0;
      r_cap_col <= '0;
      r_we      <= 1'b0;
      r_fb_addr <= '0;
      r_pix     <= '0;
      r_row     <= '0;
      r_top     <= ROW_W'(ROWS - 1);
      r_done    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
      r_we   <= w_cap;

      if (w_cap) begin
        r_pix     <= w_pix;
        r_fb_addr <= {r_row, r_cap_col};
        r_cap_col <= r_cap_col + BIN_ADDR_W'(1);
      end

      if (w_last_wr) begin
        r_done <= 1'b1;
        r_top  <= r_row;
        r_row  <= r_row + ROW_W'(1);
      end

      if (w_busy && bus.line_req) begin
        if (r_pending) r_ovr     <= 1'b1;
        else           r_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.line_req || r_pending) begin
            r_state   <= S_WAIT;
            r_pending <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.sdft_ready) begin
            r_read   <= 1'b1;
            r_addr   <= '0;
            r_rd_cnt <= '0;
            r_state  <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          if (r_rd_cnt == C_RD_LAST) begin
            r_read  <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            if (r_rd_cnt != '0) r_addr <= r_addr + BIN_ADDR_W'(1);
            r_rd_cnt <= r_rd_cnt + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (w_last_wr) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sdft_read     = r_read;
  assign bus.sdft_bin_addr = r_addr;
  assign bus.fb_we         = r_we;
  assign bus.fb_addr       = r_fb_addr;
  assign bus.fb_data       = r_pix;
  assign bus.top_row       = r_top;
  assign bus.busy          = w_busy;
  assign bus.line_done     = r_done;
  assign bus.overrun       = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_waterfall_line_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_waterfall_line_writer : directed bench with a two-stage SDFT read model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_waterfall_line_writer;

  logic clk;
  logic reset_n;

  waterfall_line_writer_if bus ();

  waterfall_line_writer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [32];
  logic [15:0] r_p1;

  // SDFT model: bin_out follows the sampled address by two clocks.
  always @(posedge clk) begin
    r_p1             <= mem[bus.sdft_bin_addr];
    bus.sdft_bin_out <= r_p1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int c0 = -1, rd_len = 0, done_cnt = 0, done_cyc = -1, ovr_cnt = 0;
  int wa[$], wd[$], wc[$], ra[$];
  bit prev_rd = 1'b0;

  initial forever begin
    @(negedge clk);
    if (bus.sdft_read === 1'b1) begin
      if (!prev_rd) begin
        c0     = cyc;
        rd_len = 0;
      end
      rd_len++;
      ra.push_back(int'(bus.sdft_bin_addr));
    end
    prev_rd = (bus.sdft_read === 1'b1);
    if (bus.fb_we === 1'b1) begin
      wa.push_back(int'(bus.fb_addr));
      wd.push_back(int'(bus.fb_data));
      wc.push_back(cyc);
    end
    if (bus.line_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.overrun === 1'b1) ovr_cnt++;
  end

  function automatic int wa_at(int i);
    return (i < wa.size()) ? wa[i] : -1;
  endfunction
  function automatic int wd_at(int i);
    return (i < wd.size()) ? wd[i] : -1;
  endfunction
  function automatic int wc_at(int i);
    return (i < wc.size()) ? wc[i] : -1;
  endfunction
  function automatic int ra_at(int i);
    return (i < ra.size()) ? ra[i] : -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(done_cnt >= target), 32'd1);
    tick();
    tick();
  endtask

  task automatic do_line();
    int d0;
    d0 = done_cnt;
    bus.line_req = 1'b1;
    tick();
    bus.line_req = 1'b0;
    wait_done(d0 + 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int wb, rb, d0, o0, t_raise, hit;
    reset_n        = 1'b0;
    bus.line_req   = 1'b0;
    bus.sdft_ready = 1'b1;
    for (int j = 0; j < 32; j++) mem[j] = 16'(16 * j);

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_read",  bus.sdft_read, 0);
    check("rst_addr",  bus.sdft_bin_addr, 0);
    check("rst_we",    bus.fb_we, 0);
    check("rst_fbadr", bus.fb_addr, 0);
    check("rst_fbdat", bus.fb_data, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_done",  bus.line_done, 0);
    check("rst_ovr",   bus.overrun, 0);
    check("rst_top",   bus.top_row, 31);
    reset_n = 1'b1;
    tick();

    // Idle sweep, row 0
    wb = wa.size();
    rb = ra.size();
    do_line();
    check("sw_rdlen", rd_len, 33);
    check("sw_ra0", ra_at(rb), 0);
    for (int k = 1; k <= 32; k++) check("sw_ra", ra_at(rb + k), k - 1);
    check("sw_nwr", wa.size() - wb, 32);
    for (int i = 0; i < 32; i++) begin
      check("sw_addr", wa_at(wb + i), i);
      check("sw_data", wd_at(wb + i), (i > 15) ? 15 : i);
      check("sw_wcyc", wc_at(wb + i) - c0, i + 4);
    end
    check("sw_donecyc", done_cyc - c0, 36);
    check("sw_top", bus.top_row, 0);

    // Saturation, row 1
    for (int j = 0; j < 32; j++) mem[j] = 16'h0000;
    mem[0] = 16'h0035; mem[1] = 16'h00F0; mem[2] = 16'h00FF;
    mem[3] = 16'h0100; mem[4] = 16'hFFFF;
    wb = wa.size();
    do_line();
    check("sat_addr0", wa_at(wb), 32);
    check("sat_d0", wd_at(wb + 0), 3);
    check("sat_d1", wd_at(wb + 1), 15);
    check("sat_d2", wd_at(wb + 2), 15);
    check("sat_d3", wd_at(wb + 3), 15);
    check("sat_d4", wd_at(wb + 4), 15);
    check("sat_d5", wd_at(wb + 5), 0);
    check("sat_top", bus.top_row, 1);

    // Busy SDFT, row 2
    for (int j = 0; j < 32; j++) mem[j] = 16'(16 * j);
    bus.sdft_ready = 1'b0;
    d0 = done_cnt;
    bus.line_req = 1'b1;
    tick();
    bus.line_req = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("bz_read", bus.sdft_read, 0);
      check("bz_busy", bus.busy, 1);
      tick();
    end
    bus.sdft_ready = 1'b1;
    t_raise = cyc;
    wb = wa.size();
    wait_done(d0 + 1);
    check("bz_c0", c0, t_raise + 1);
    check("bz_donecyc", done_cyc - c0, 36);
    check("bz_addr0", wa_at(wb), 64);
    check("bz_top", bus.top_row, 2);

    // Reset mid-sweep at column 10
    bus.line_req = 1'b1;
    tick();
    bus.line_req = 1'b0;
    hit = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.fb_we === 1'b1 && bus.fb_addr[4:0] == 5'd10) begin
        hit = 1;
        break;
      end
    end
    check("mr_reached", hit, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mr_we",   bus.fb_we, 0);
    check("mr_read", bus.sdft_read, 0);
    check("mr_top",  bus.top_row, 31);
    check("mr_busy", bus.busy, 0);
    reset_n = 1'b1;
    tick();
    wb = wa.size();
    do_line();
    check("mr_nwr",   wa.size() - wb, 32);
    check("mr_addr0", wa_at(wb), 0);
    check("mr_top2",  bus.top_row, 0);

    // Queueing: three requests during one sweep
    do_reset();
    d0 = done_cnt;
    o0 = ovr_cnt;
    wb = wa.size();
    bus.line_req = 1'b1;
    tick();
    bus.line_req = 1'b0;
    hit = 0;
    for (int n = 0; n < 20 && hit == 0; n++) begin
      tick();
      if (bus.sdft_read === 1'b1) hit = 1;
    end
    check("q_started", hit, 1);
    bus.line_req = 1'b1;
    tick();
    bus.line_req = 1'b0;
    @(negedge clk);
    check("q_ovr1", bus.overrun, 0);
    for (int r = 0; r < 2; r++) begin
      tick();
      bus.line_req = 1'b1;
      tick();
      bus.line_req = 1'b0;
      @(negedge clk);
      check("q_ovr", bus.overrun, 1);
    end
    wait_done(d0 + 2);
    repeat (60) tick();
    check("q_lines",  done_cnt - d0, 2);
    check("q_ovrcnt", ovr_cnt - o0, 2);
    check("q_nwr",    wa.size() - wb, 64);
    check("q_a0",  wa_at(wb), 0);
    check("q_a31", wa_at(wb + 31), 31);
    check("q_a32", wa_at(wb + 32), 32);
    check("q_a63", wa_at(wb + 63), 63);
    check("q_top", bus.top_row, 1);

    // Wrap: 33 consecutive lines from a fresh reset
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      wb = wa.size();
      do_line();
      if (k == 32) begin
        check("wr32_first", wa_at(wb), 992);
        check("wr32_last",  wa_at(wb + 31), 1023);
        check("wr32_top",   bus.top_row, 31);
      end
      if (k == 33) begin
        check("wr33_first", wa_at(wb), 0);
        check("wr33_last",  wa_at(wb + 31), 31);
        check("wr33_top",   bus.top_row, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
